// File: rtl/io_intr_ctrl.sv
// Memory-mapped interrupt controller: channel 0 is an internal down-counting timer,
// channels 1..NUM_CH-1 are edge-triggered external lines, serviced via an intr/inta handshake.
module io_intr_ctrl #(
  parameter int          NUM_CH  = 4,
  parameter int          TIMER_W = 16,
  parameter logic [31:0] BASE    = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_cs,
  input  logic              io_rd,
  input  logic              io_wr,
  input  logic [31:0]       io_address,
  input  logic [31:0]       io_d_in,
  output logic [31:0]       io_out,
  input  logic [NUM_CH-2:0] irq_src,
  output logic              intr,
  input  logic              inta
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic [2:0] OFF_PEND   = 3'd0;
  localparam logic [2:0] OFF_MASK   = 3'd1;
  localparam logic [2:0] OFF_VECTOR = 3'd2;
  localparam logic [2:0] OFF_RELOAD = 3'd3;
  localparam logic [2:0] OFF_TCTRL  = 3'd4;
  localparam logic [2:0] OFF_TCOUNT = 3'd5;

  logic [NUM_CH-1:0]  pend;
  logic [NUM_CH-1:0]  mask;
  logic               vec_valid;
  logic [3:0]         vec_id;
  logic [TIMER_W-1:0] reload;
  logic [TIMER_W-1:0] tcount;
  logic               run;
  logic               periodic;
  logic [NUM_CH-2:0]  irq_prev;
  logic               armed;
  logic [1:0]         state;
  logic [1:0]         state_next;

  logic               hit;
  logic               rd_en;
  logic               wr_en;
  logic [2:0]         off;
  logic [NUM_CH-2:0]  rise;
  logic               timer_fire;
  logic [NUM_CH-1:0]  hw_set;
  logic [NUM_CH-1:0]  w1c;
  logic [NUM_CH-1:0]  ack_clr;
  logic [NUM_CH-1:0]  masked;
  logic [3:0]         low_id;
  logic               ack_take;
  logic               unused_bits;

  assign hit   = (io_address[31:5] == BASE[31:5]);
  assign off   = io_address[4:2];
  assign rd_en = io_cs & io_rd & hit;
  assign wr_en = io_cs & io_wr & hit;

  // armed stays low for the first cycle after reset so lines held high across release are ignored
  assign rise       = irq_src & ~irq_prev & {(NUM_CH-1){armed}};
  assign timer_fire = run & (tcount == TIMER_W'(1));
  assign hw_set     = {rise, timer_fire};
  assign w1c        = (wr_en && (off == OFF_PEND)) ? io_d_in[NUM_CH-1:0] : {NUM_CH{1'b0}};
  assign masked     = pend & mask;
  assign unused_bits = ^{io_address[1:0], io_d_in};

  // Read mux: combinational, zero outside a qualified hit.
  always_comb begin
    io_out = 32'h0000_0000;
    if (rd_en) begin
      case (off)
        OFF_PEND:   io_out[NUM_CH-1:0]  = pend;
        OFF_MASK:   io_out[NUM_CH-1:0]  = mask;
        OFF_VECTOR: begin
          io_out[31]  = vec_valid;
          io_out[3:0] = vec_id;
        end
        OFF_RELOAD: io_out[TIMER_W-1:0] = reload;
        OFF_TCTRL:  io_out[1:0]         = {periodic, run};
        OFF_TCOUNT: io_out[TIMER_W-1:0] = tcount;
        default:    io_out              = 32'h0000_0000;
      endcase
    end else begin
      io_out = 32'h0000_0000;
    end
  end

  // Lowest-index enabled channel (descending scan leaves the smallest index last).
  always_comb begin
    low_id = 4'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (masked[i]) begin
        low_id = 4'(i);
      end else begin
        low_id = low_id;
      end
    end
  end

  // Handshake next state and the acknowledge-clear mask.
  always_comb begin
    state_next = state;
    ack_take   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (masked != {NUM_CH{1'b0}}) state_next = ST_REQ;
        else                          state_next = ST_IDLE;
      end
      ST_REQ: begin
        if (masked == {NUM_CH{1'b0}}) begin
          state_next = ST_IDLE;
        end else if (inta) begin
          state_next = ST_ACK;
          ack_take   = 1'b1;
        end else begin
          state_next = ST_REQ;
        end
      end
      ST_ACK: begin
        if (!inta) state_next = ST_IDLE;
        else       state_next = ST_ACK;
      end
      default: state_next = ST_IDLE;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      ack_clr[i] = ack_take && (low_id == 4'(i));
    end
  end

  // Register state: reset dominates; hardware sets win over W1C and acknowledge clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend      <= {NUM_CH{1'b0}};
      mask      <= {NUM_CH{1'b0}};
      vec_valid <= 1'b0;
      vec_id    <= 4'd0;
      reload    <= {TIMER_W{1'b0}};
      tcount    <= {TIMER_W{1'b0}};
      run       <= 1'b0;
      periodic  <= 1'b0;
      irq_prev  <= {(NUM_CH-1){1'b0}};
      armed     <= 1'b0;
      state     <= ST_IDLE;
      intr      <= 1'b0;
    end else begin
      state    <= state_next;
      intr     <= (state_next == ST_REQ);
      irq_prev <= irq_src;
      armed    <= 1'b1;
      pend     <= (pend & ~w1c & ~ack_clr) | hw_set;

      if (wr_en && (off == OFF_MASK)) mask <= io_d_in[NUM_CH-1:0];

      if (ack_take) begin
        vec_valid <= 1'b1;
        vec_id    <= low_id;
      end else if (rd_en && !wr_en && (off == OFF_VECTOR)) begin
        vec_valid <= 1'b0;
      end

      if (wr_en && (off == OFF_RELOAD)) begin
        reload <= io_d_in[TIMER_W-1:0];
        tcount <= io_d_in[TIMER_W-1:0];
      end else if (wr_en && (off == OFF_TCTRL) && io_d_in[0] && (tcount == {TIMER_W{1'b0}})) begin
        tcount <= reload;
      end else if (timer_fire) begin
        tcount <= periodic ? reload : {TIMER_W{1'b0}};
      end else if (run && (tcount != {TIMER_W{1'b0}})) begin
        tcount <= tcount - TIMER_W'(1);
      end

      if (wr_en && (off == OFF_TCTRL)) begin
        run      <= io_d_in[0];
        periodic <= io_d_in[1];
      end else if (timer_fire && !periodic) begin
        run <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_io_intr_ctrl.sv
// Bench for io_intr_ctrl: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a behavioural model of the register block.
module tb_io_intr_ctrl;

  localparam int          NUM_CH  = 4;
  localparam int          TIMER_W = 16;
  localparam logic [31:0] TB_BASE = 32'h4000_0000;
  localparam logic [31:0] CHM     = 32'h0000_000F;
  localparam logic [31:0] TMK     = 32'h0000_FFFF;

  logic              clk;
  logic              reset;
  logic              io_cs, io_rd, io_wr;
  logic [31:0]       io_address, io_d_in, io_out;
  logic [NUM_CH-2:0] irq_src;
  logic              intr, inta;

  io_intr_ctrl #(.NUM_CH(NUM_CH), .TIMER_W(TIMER_W), .BASE(TB_BASE)) dut (
    .clk(clk), .reset(reset), .io_cs(io_cs), .io_rd(io_rd), .io_wr(io_wr),
    .io_address(io_address), .io_d_in(io_d_in), .io_out(io_out),
    .irq_src(irq_src), .intr(intr), .inta(inta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  logic [31:0] m_pend, m_mask, m_reload, m_tcount;
  logic [3:0]  m_vid;
  logic        m_vvalid, m_run, m_per, m_fresh;
  logic [NUM_CH-2:0] m_prev;
  int          m_hs;       // 0 idle, 1 requesting, 2 acknowledged
  bit          m_known = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rdata();
    logic [31:0] a;
    a = io_address;
    if (!(io_cs && io_rd) || (a[31:5] != TB_BASE[31:5])) return 32'h0;
    case (a[4:2])
      3'd0:    return m_pend;
      3'd1:    return m_mask;
      3'd2:    return {m_vvalid, 27'h0, m_vid};
      3'd3:    return m_reload;
      3'd4:    return {30'h0, m_per, m_run};
      3'd5:    return m_tcount;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] en, setv, clr, cnt, dat;
    logic [2:0]  off;
    logic        hitv, rdv, wrv, fire, ackd, run_n;
    int          hs_n, id;
    if (reset) begin
      m_pend = 0; m_mask = 0; m_reload = 0; m_tcount = 0; m_vid = 0; m_vvalid = 0;
      m_run = 0; m_per = 0; m_prev = 0; m_hs = 0; m_fresh = 1; m_known = 1;
      return;
    end
    dat  = io_d_in;
    hitv = (io_address[31:5] == TB_BASE[31:5]);
    off  = io_address[4:2];
    rdv  = io_cs && io_rd && hitv;
    wrv  = io_cs && io_wr && hitv;
    en   = m_pend & m_mask;
    fire = m_run && (m_tcount == 1);
    setv = fire ? 32'h1 : 32'h0;
    if (!m_fresh)
      for (int k = 0; k < NUM_CH - 1; k++)
        if (irq_src[k] && !m_prev[k]) setv = setv | (32'h1 << (k + 1));
    clr  = (wrv && off == 3'd0) ? (dat & CHM) : 32'h0;
    ackd = 0;
    hs_n = m_hs;
    if (m_hs == 0) begin
      if (en != 0) hs_n = 1;
    end else if (m_hs == 1) begin
      if (en == 0) hs_n = 0;
      else if (inta) begin
        id = 0;
        for (int c = NUM_CH - 1; c >= 0; c--) if (en[c]) id = c;
        hs_n = 2; ackd = 1; clr = clr | (32'h1 << id);
        m_vvalid = 1; m_vid = id[3:0];
      end
    end else begin
      if (!inta) hs_n = 0;
    end
    if (!ackd && rdv && !wrv && off == 3'd2) m_vvalid = 0;
    m_pend = ((m_pend & ~clr) | setv) & CHM;
    if (wrv && off == 3'd1) m_mask = dat & CHM;
    cnt = m_tcount; run_n = m_run;
    if (wrv && off == 3'd3) begin m_reload = dat & TMK; cnt = dat & TMK; end
    else if (wrv && off == 3'd4 && dat[0] && m_tcount == 0) cnt = m_reload;
    else if (fire) cnt = m_per ? m_reload : 0;
    else if (m_run && m_tcount != 0) cnt = m_tcount - 1;
    if (wrv && off == 3'd4) begin run_n = dat[0]; m_per = dat[1]; end
    else if (fire && !m_per) run_n = 0;
    m_run = run_n; m_tcount = cnt;
    m_prev = irq_src; m_fresh = 0; m_hs = hs_n;
  endtask

  task automatic finish_cyc();
    if (m_known) begin
      check("io_out", io_out, model_rdata());
      check("intr", {31'h0, intr}, {31'h0, (m_hs == 1)});
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic cyc();
    #1;
    finish_cyc();
  endtask

  task automatic bus_wr_addr(logic [31:0] addr, logic [31:0] data);
    io_cs = 1; io_wr = 1; io_rd = 0; io_address = addr; io_d_in = data;
    cyc();
    io_cs = 0; io_wr = 0;
  endtask

  task automatic bus_wr(logic [2:0] off, logic [31:0] data);
    bus_wr_addr(TB_BASE + {27'h0, off, 2'b00}, data);
  endtask

  task automatic rd_addr_lit(string name, logic [31:0] addr, logic [31:0] lit);
    io_cs = 1; io_rd = 1; io_wr = 0; io_address = addr;
    #1;
    check({name, " dut"}, io_out, lit);
    check({name, " model"}, model_rdata(), lit);
    finish_cyc();
    io_cs = 0; io_rd = 0;
  endtask

  task automatic rd_lit(string name, logic [2:0] off, logic [31:0] lit);
    rd_addr_lit(name, TB_BASE + {27'h0, off, 2'b00}, lit);
  endtask

  task automatic intr_lit(string name, logic v);
    check({name, " dut"}, {31'h0, intr}, {31'h0, v});
    check({name, " model"}, {31'h0, (m_hs == 1)}, {31'h0, v});
  endtask

  initial begin
    reset = 1; io_cs = 0; io_rd = 0; io_wr = 0; io_address = 0; io_d_in = 0;
    irq_src = 0; inta = 0;
    @(negedge clk);
    cyc(); cyc();
    reset = 0;

    // reset state
    intr_lit("rst intr", 1'b0);
    for (int o = 0; o < 6; o++) rd_lit("rst reg", o[2:0], 32'h0);

    // single external event through the full handshake
    bus_wr(3'd1, 32'h6);
    irq_src = 3'b010; cyc(); irq_src = 3'b000;
    intr_lit("e1 intr lo", 1'b0);
    rd_lit("e1 pend", 3'd0, 32'h4);
    intr_lit("e1 intr hi", 1'b1);
    inta = 1; cyc();
    intr_lit("e1 intr ack", 1'b0);
    rd_lit("e1 vector", 3'd2, 32'h8000_0002);
    rd_lit("e1 pend clr", 3'd0, 32'h0);
    rd_lit("e1 vector rdclr", 3'd2, 32'h0000_0002);
    inta = 0; cyc();

    // periodic timer
    bus_wr(3'd3, 32'd5);
    bus_wr(3'd1, 32'h1);
    bus_wr(3'd4, 32'h3);
    rd_lit("tp 5", 3'd5, 32'd5);
    rd_lit("tp 4", 3'd5, 32'd4);
    rd_lit("tp 3", 3'd5, 32'd3);
    rd_lit("tp 2", 3'd5, 32'd2);
    rd_lit("tp 1", 3'd5, 32'd1);
    rd_lit("tp 5b", 3'd5, 32'd5);
    rd_lit("tp pend", 3'd0, 32'h1);
    bus_wr(3'd0, 32'h1);
    bus_wr(3'd4, 32'h0);

    // one-shot timer
    bus_wr(3'd3, 32'd3);
    bus_wr(3'd4, 32'h1);
    cyc(); cyc(); cyc();
    rd_lit("os tctrl", 3'd4, 32'h0);
    rd_lit("os tcount", 3'd5, 32'h0);
    rd_lit("os pend", 3'd0, 32'h1);
    cyc(); cyc(); cyc();
    rd_lit("os tcount idle", 3'd5, 32'h0);
    bus_wr(3'd0, 32'hF);
    rd_lit("os pend clr", 3'd0, 32'h0);
    bus_wr(3'd1, 32'h0);

    // simultaneous events: lowest index served first
    bus_wr(3'd1, 32'hF);
    irq_src = 3'b101; cyc(); irq_src = 3'b000;
    cyc();
    intr_lit("pr intr", 1'b1);
    inta = 1; cyc();
    rd_lit("pr vec1", 3'd2, 32'h8000_0001);
    inta = 0; cyc(); cyc();
    inta = 1; cyc();
    rd_lit("pr vec3", 3'd2, 32'h8000_0003);
    inta = 0; cyc();

    // set wins over a same-cycle W1C
    bus_wr(3'd1, 32'h0);
    irq_src = 3'b001; cyc(); irq_src = 3'b000; cyc();
    io_cs = 1; io_wr = 1; io_address = TB_BASE; io_d_in = 32'h2; irq_src = 3'b001;
    cyc();
    io_cs = 0; io_wr = 0; irq_src = 3'b000;
    rd_lit("coll pend", 3'd0, 32'h2);

    // read+write together: write takes effect, read shows old data
    io_cs = 1; io_rd = 1; io_wr = 1; io_address = TB_BASE + 32'h4; io_d_in = 32'h5;
    #1;
    check("rw old dut", io_out, 32'h0);
    finish_cyc();
    io_cs = 0; io_rd = 0; io_wr = 0;
    rd_lit("rw new", 3'd1, 32'h5);

    // reset in the middle of an acknowledge, irq held high across release
    bus_wr(3'd1, 32'hF);
    cyc();
    inta = 1; cyc();
    reset = 1; irq_src = 3'b001; cyc();
    reset = 0; inta = 0;
    intr_lit("mr intr", 1'b0);
    for (int o = 0; o < 6; o++) rd_lit("mr reg", o[2:0], 32'h0);
    irq_src = 3'b000; cyc();
    bus_wr(3'd1, 32'h4);
    irq_src = 3'b010; cyc(); irq_src = 3'b000; cyc();
    intr_lit("mr intr again", 1'b1);
    inta = 1; cyc();
    rd_lit("mr vector", 3'd2, 32'h8000_0002);
    inta = 0; cyc();

    // unmapped offset and foreign base
    rd_lit("oob read", 3'd6, 32'h0);
    bus_wr(3'd6, 32'hFFFF_FFFF);
    rd_addr_lit("base miss read", (TB_BASE ^ 32'h0000_0100) + 32'h4, 32'h0);
    bus_wr_addr((TB_BASE ^ 32'h0000_0100) + 32'h4, 32'hF);
    rd_lit("base miss mask", 3'd1, 32'h4);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [2:0] o;
      reset = ($urandom_range(0, 299) == 0);
      r = $urandom_range(0, 9);
      io_cs = ($urandom_range(0, 9) != 0);
      io_wr = (r < 3);
      io_rd = (r >= 3 && r < 7);
      o = 3'($urandom_range(0, 7));
      io_address = TB_BASE + {27'h0, o, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 15) == 0) io_address = io_address ^ 32'h0010_0000;
      io_d_in = (o == 3'd3 || o == 3'd4) ? 32'($urandom_range(0, 9)) : $urandom;
      if ($urandom_range(0, 3) == 0) irq_src = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) inta = ~inta;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
